// File: rtl/gpio_apb_irq_if.sv
// gpio_apb_irq_if - APB3 bus bundle for the gpio_apb_irq peripheral.
//
// Signals (names match the peripheral's APB port list):
//   in_paddr    32  address, only [4:2] decoded by the slave
//   in_psel     1   select
//   in_penable  1   enable (access phase when both psel and penable are high)
//   in_pprot    3   protection, ignored by the slave
//   in_pwrite   1   1 = write
//   in_pwdata   32  write data
//   in_pstrb    4   byte-lane write strobes
//   in_pready   1   slave ready (zero wait states)
//   in_prdata   32  read data
//   in_pslverr  1   error response, valid while in_pready is high
//
// Modports: master drives the request, slave drives the response.

interface gpio_apb_irq_if;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic [2:0]  in_pprot;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  modport master (
    output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    input  in_pready, in_prdata, in_pslverr
  );

  modport slave (
    input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    output in_pready, in_prdata, in_pslverr
  );
endinterface

// File: rtl/gpio_apb_irq.sv
// gpio_apb_irq - parametrised APB3 GPIO peripheral with 7-segment drive and
// edge-detect interrupt.
//
// Register slots (in_paddr[4:2]):
//   0 OUT (RW)   1 IN (RO)   2 SEG (RW, nibble k = hex digit k)
//   3 SEG_EN (RW)   4 RISE_EN (RW)   5 FALL_EN (RW)   6 IRQ_STATUS (W1C)
//   7 unmapped (error, reads 0)
//
// Ports:
//   clock     system clock
//   reset     synchronous, active-high reset
//   apb       APB3 slave port (gpio_apb_irq_if.slave), zero wait states
//   gpio_out  GPIO_W output pins
//   gpio_in   GPIO_W asynchronous input pins
//   gpio_seg  8*SEG_N segment lines, digit k on [8k+7:8k], active-low a..g,dp
//   irq       level interrupt, OR of IRQ_STATUS

module gpio_apb_irq #(
  parameter int GPIO_W      = 16,
  parameter int SEG_N       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  gpio_apb_irq_if.slave       apb,
  output logic [GPIO_W-1:0]   gpio_out,
  input  logic [GPIO_W-1:0]   gpio_in,
  output logic [8*SEG_N-1:0]  gpio_seg,
  output logic                irq
);

  typedef enum logic [2:0] {
    SLOT_OUT     = 3'd0,
    SLOT_IN      = 3'd1,
    SLOT_SEG     = 3'd2,
    SLOT_SEG_EN  = 3'd3,
    SLOT_RISE_EN = 3'd4,
    SLOT_FALL_EN = 3'd5,
    SLOT_STATUS  = 3'd6,
    SLOT_NONE    = 3'd7
  } slot_e;

  // Active-low segment pattern (a..g in bits 7..1, dp in bit 0) for one hex digit.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      4'hF: s = 8'h71;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  logic [GPIO_W-1:0]  out_q;
  logic [4*SEG_N-1:0] seg_q;
  logic [SEG_N-1:0]   seg_en_q;
  logic [GPIO_W-1:0]  rise_en_q;
  logic [GPIO_W-1:0]  fall_en_q;
  logic [GPIO_W-1:0]  status_q;
  logic [GPIO_W-1:0]  sync_q [SYNC_STAGES];
  logic [GPIO_W-1:0]  prev_q;

  logic               access;
  logic               bus_err;
  logic               wr_ok;
  slot_e              slot;
  logic [31:0]        lane_mask;
  logic [31:0]        out_m, seg_m, seg_en_m, rise_m, fall_m, clr_m;
  logic [GPIO_W-1:0]  status_clr;
  logic [GPIO_W-1:0]  sync_s;
  logic [GPIO_W-1:0]  rise, fall;
  logic [31:0]        rdata;

  assign access  = apb.in_psel & apb.in_penable;
  assign slot    = slot_e'(apb.in_paddr[4:2]);
  // Unmapped slot and writes to the read-only IN register are rejected and
  // must not touch any state.
  assign bus_err = access & ((slot == SLOT_NONE) | (apb.in_pwrite & (slot == SLOT_IN)));
  assign wr_ok   = access & apb.in_pwrite & ~bus_err;

  assign apb.in_pready  = access;
  assign apb.in_pslverr = bus_err;

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < 4; b++) begin
      lane_mask[8*b +: 8] = {8{apb.in_pstrb[b]}};
    end
  end

  // Registers are widened to 32 bits, merged lane-by-lane with the write
  // data, then truncated back so bits beyond the register width never store.
  assign out_m    = (32'(out_q)     & ~lane_mask) | (apb.in_pwdata & lane_mask);
  assign seg_m    = (32'(seg_q)     & ~lane_mask) | (apb.in_pwdata & lane_mask);
  assign seg_en_m = (32'(seg_en_q)  & ~lane_mask) | (apb.in_pwdata & lane_mask);
  assign rise_m   = (32'(rise_en_q) & ~lane_mask) | (apb.in_pwdata & lane_mask);
  assign fall_m   = (32'(fall_en_q) & ~lane_mask) | (apb.in_pwdata & lane_mask);
  assign clr_m    = apb.in_pwdata & lane_mask;

  assign status_clr = (wr_ok && slot == SLOT_STATUS) ? clr_m[GPIO_W-1:0] : '0;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~prev_q & rise_en_q;
  assign fall   = ~sync_s & prev_q & fall_en_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_s;
    end
  end

  // Status: a new qualifying edge is ORed in after the clear, so set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~status_clr) | rise | fall;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q     <= '0;
      seg_q     <= '0;
      seg_en_q  <= '1;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr_ok) begin
      case (slot)
        SLOT_OUT:     out_q     <= out_m[GPIO_W-1:0];
        SLOT_SEG:     seg_q     <= seg_m[4*SEG_N-1:0];
        SLOT_SEG_EN:  seg_en_q  <= seg_en_m[SEG_N-1:0];
        SLOT_RISE_EN: rise_en_q <= rise_m[GPIO_W-1:0];
        SLOT_FALL_EN: fall_en_q <= fall_m[GPIO_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (access) begin
      case (slot)
        SLOT_OUT:     rdata = 32'(out_q);
        SLOT_IN:      rdata = 32'(sync_s);
        SLOT_SEG:     rdata = 32'(seg_q);
        SLOT_SEG_EN:  rdata = 32'(seg_en_q);
        SLOT_RISE_EN: rdata = 32'(rise_en_q);
        SLOT_FALL_EN: rdata = 32'(fall_en_q);
        SLOT_STATUS:  rdata = 32'(status_q);
        default:      rdata = '0;
      endcase
    end
  end

  assign apb.in_prdata = rdata;

  for (genvar k = 0; k < SEG_N; k++) begin : g_digit
    assign gpio_seg[8*k +: 8] = seg_en_q[k] ? hex_to_seg(seg_q[4*k +: 4]) : 8'hFF;
  end

  assign gpio_out = out_q;
  assign irq      = |status_q;

  // Bus bits that are ignored by design, and merge bits above register width.
  logic unused_bits;
  assign unused_bits = ^{apb.in_pprot, apb.in_paddr[31:5], apb.in_paddr[1:0],
                         out_m, seg_m, seg_en_m, rise_m, fall_m, clr_m};

endmodule

// File: tb/tb_gpio_apb_irq.sv
// tb_gpio_apb_irq - self-checking bench for gpio_apb_irq.
//
// Drives APB transfers through gpio_apb_irq_if and compares pins and read
// data against a register-level reference model that tracks each register as
// a plain 32-bit value and models the input path as a delay line of sampled
// pin values.

module tb_gpio_apb_irq;
  localparam int GPIO_W      = 16;
  localparam int SEG_N       = 8;
  localparam int SYNC_STAGES = 2;

  localparam logic [31:0] W_MASK    = 32'((64'd1 << GPIO_W) - 64'd1);
  localparam logic [31:0] SEGV_MASK = 32'((64'd1 << (4*SEG_N)) - 64'd1);
  localparam logic [31:0] EN_MASK   = 32'((64'd1 << SEG_N) - 64'd1);

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  logic                clock = 1'b0;
  logic                reset;
  logic [GPIO_W-1:0]   gpio_out;
  logic [GPIO_W-1:0]   gpio_in;
  logic [8*SEG_N-1:0]  gpio_seg;
  logic                irq;

  gpio_apb_irq_if apb ();

  gpio_apb_irq #(
    .GPIO_W      (GPIO_W),
    .SEG_N       (SEG_N),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .apb      (apb),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .gpio_seg (gpio_seg),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] m_out, m_seg, m_en, m_rise, m_fall, m_status;
  logic [31:0] m_hist [$];

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic model_reset();
    m_out = 0; m_seg = 0; m_en = EN_MASK; m_rise = 0; m_fall = 0; m_status = 0;
    m_hist = {};
    for (int i = 0; i <= SYNC_STAGES; i++) m_hist.push_back(32'd0);
  endtask

  // Synchronised value seen by software: the pin sampled SYNC_STAGES-1 edges ago.
  function automatic logic [31:0] model_in();
    return m_hist[SYNC_STAGES-1];
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] slot);
    case (slot)
      3'd0: return m_out;
      3'd1: return model_in();
      3'd2: return m_seg;
      3'd3: return m_en;
      3'd4: return m_rise;
      3'd5: return m_fall;
      3'd6: return m_status;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] model_seg();
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < SEG_N; k++)
      r[8*k +: 8] = m_en[k] ? SEG_TABLE[m_seg[4*k +: 4]] : 8'hFF;
    return r;
  endfunction

  // Advance the model by one rising edge using the stimulus present at that edge.
  task automatic model_edge();
    logic [31:0] s, p, set, clr, mask, d;
    if (reset) begin
      model_reset();
      return;
    end
    s    = m_hist[SYNC_STAGES-1];
    p    = m_hist[SYNC_STAGES];
    set  = (s & ~p & m_rise) | (~s & p & m_fall);
    clr  = 0;
    mask = lanes(apb.in_pstrb);
    d    = apb.in_pwdata;
    if (apb.in_psel && apb.in_penable && apb.in_pwrite) begin
      case (apb.in_paddr[4:2])
        3'd0: m_out  = ((m_out  & ~mask) | (d & mask)) & W_MASK;
        3'd2: m_seg  = ((m_seg  & ~mask) | (d & mask)) & SEGV_MASK;
        3'd3: m_en   = ((m_en   & ~mask) | (d & mask)) & EN_MASK;
        3'd4: m_rise = ((m_rise & ~mask) | (d & mask)) & W_MASK;
        3'd5: m_fall = ((m_fall & ~mask) | (d & mask)) & W_MASK;
        3'd6: clr    = d & mask & W_MASK;
        default: ;
      endcase
    end
    m_status = ((m_status & ~clr) | set) & W_MASK;
    m_hist.push_front(32'(gpio_in));
    void'(m_hist.pop_back());
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pins(input string tag);
    checkOutput({tag, "_gpio_out"}, 64'(gpio_out), 64'(m_out));
    checkOutput({tag, "_irq"}, 64'(irq), 64'(m_status != 0));
    checkOutput({tag, "_gpio_seg"}, 64'(gpio_seg), model_seg());
  endtask

  // One complete APB transfer (setup + access); response checked in the access phase.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input string tag);
    logic exp_err;
    apb.in_psel    = 1'b1;
    apb.in_penable = 1'b0;
    apb.in_pwrite  = wr;
    apb.in_paddr   = addr;
    apb.in_pwdata  = data;
    apb.in_pstrb   = strb;
    apb.in_pprot   = 3'($urandom_range(0, 7));
    step();
    apb.in_penable = 1'b1;
    #1;
    exp_err = (addr[4:2] == 3'd7) || (wr && addr[4:2] == 3'd1);
    checkOutput({tag, "_pready"}, 64'(apb.in_pready), 64'd1);
    checkOutput({tag, "_pslverr"}, 64'(apb.in_pslverr), 64'(exp_err));
    if (!wr) checkOutput({tag, "_prdata"}, 64'(apb.in_prdata), 64'(model_read(addr[4:2])));
    step();
    apb.in_psel    = 1'b0;
    apb.in_penable = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int sl = 0; sl < 8; sl++)
      applyStimulus(1'b0, 32'(sl) << 2, 32'd0, 4'h0, $sformatf("%s_rd%0d", tag, sl));
  endtask

  initial begin
    reset          = 1'b1;
    gpio_in        = '0;
    apb.in_psel    = 1'b0;
    apb.in_penable = 1'b0;
    apb.in_pwrite  = 1'b0;
    apb.in_paddr   = '0;
    apb.in_pwdata  = '0;
    apb.in_pstrb   = '0;
    apb.in_pprot   = '0;
    model_reset();
    @(negedge clock);
    step();
    step();
    reset = 1'b0;

    $display("[TB] reset state");
    check_pins("reset");
    checkOutput("reset_seg_zero", 64'(gpio_seg), {SEG_N{8'h03}});
    checkOutput("reset_irq_low", 64'(irq), 64'd0);
    apb.in_psel = 1'b1; apb.in_paddr = 32'h8; #1;
    checkOutput("setup_prdata_zero", 64'(apb.in_prdata), 64'd0);
    apb.in_psel = 1'b0;
    read_all("reset");

    $display("[TB] OUT byte strobes");
    applyStimulus(1'b1, 32'h0, 32'h0000A5C3, 4'b0011, "out_w1");
    applyStimulus(1'b1, 32'h0, 32'h0000FF00, 4'b0010, "out_w2");
    checkOutput("out_merge", 64'(gpio_out), 64'h0000FFC3);
    applyStimulus(1'b1, 32'h0, 32'h00001234, 4'b0000, "out_w3");
    checkOutput("out_nostrb", 64'(gpio_out), 64'h0000FFC3);
    check_pins("out");

    $display("[TB] segment decode and blanking");
    applyStimulus(1'b1, 32'h8, 32'h89ABCDEF, 4'hF, "seg_w");
    applyStimulus(1'b1, 32'hC, 32'h0000000F, 4'hF, "segen_w");
    checkOutput("seg_pattern", 64'(gpio_seg), 64'hFFFFFFFF_63856171);
    check_pins("seg");

    $display("[TB] rising edge detect");
    applyStimulus(1'b1, 32'h10, 32'h00000001, 4'hF, "rise_w");
    gpio_in[0] = 1'b1;
    step();
    checkOutput("rise_irq_early", 64'(irq), 64'd0);
    applyStimulus(1'b0, 32'h4, 32'd0, 4'h0, "in_rd");
    checkOutput("rise_irq_set", 64'(irq), 64'd1);
    applyStimulus(1'b0, 32'h18, 32'd0, 4'h0, "status_rd1");
    gpio_in[0] = 1'b0;
    repeat (4) step();
    check_pins("fall_disabled");
    applyStimulus(1'b0, 32'h18, 32'd0, 4'h0, "status_rd2");

    $display("[TB] W1C versus simultaneous set");
    gpio_in[0] = 1'b1;
    step();
    applyStimulus(1'b1, 32'h18, 32'h00000001, 4'b0001, "w1c_race");
    checkOutput("w1c_race_irq", 64'(irq), 64'd1);
    applyStimulus(1'b0, 32'h18, 32'd0, 4'h0, "status_rd3");
    repeat (3) step();
    applyStimulus(1'b1, 32'h18, 32'h00000001, 4'b0001, "w1c_idle");
    checkOutput("w1c_idle_irq", 64'(irq), 64'd0);
    check_pins("w1c");

    $display("[TB] error responses");
    applyStimulus(1'b1, 32'h4, 32'hFFFFFFFF, 4'hF, "err_in_w");
    applyStimulus(1'b1, 32'h1C, 32'hFFFFFFFF, 4'hF, "err_s7_w");
    checkOutput("err_out_kept", 64'(gpio_out), 64'h0000FFC3);
    read_all("err");
    check_pins("err");

    $display("[TB] reset during access phase");
    gpio_in[0] = 1'b0;
    repeat (3) step();
    gpio_in[0] = 1'b1;
    repeat (3) step();
    checkOutput("pre_reset_irq", 64'(irq), 64'd1);
    apb.in_psel = 1'b1; apb.in_penable = 1'b0; apb.in_pwrite = 1'b1;
    apb.in_paddr = 32'h0; apb.in_pwdata = 32'h00001111; apb.in_pstrb = 4'hF;
    step();
    apb.in_penable = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    apb.in_psel = 1'b0; apb.in_penable = 1'b0;
    checkOutput("rst_mid_out", 64'(gpio_out), 64'd0);
    checkOutput("rst_mid_irq", 64'(irq), 64'd0);
    check_pins("rst_mid");
    read_all("rst_mid");

    $display("[TB] randomized traffic");
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 4))
        0, 1: applyStimulus(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)),
                            $sformatf("rnd_w%0d", it));
        2:    applyStimulus(1'b0, $urandom, 32'd0, 4'h0, $sformatf("rnd_r%0d", it));
        3:    begin gpio_in = GPIO_W'($urandom); step(); end
        default: step();
      endcase
      check_pins($sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_apb_irq.md
Name: gpio_apb_irq

Overview:
Parametrised APB3 GPIO peripheral, successor to the fixed 16-bit GPIO/7-segment block on the ysyxSoC APB fabric.
- Scales output and input pin width and 7-segment digit count.
- Synchronises inputs and detects rising/falling edges into sticky, write-1-to-clear status feeding one level interrupt.
- Honours byte strobes as a read-modify-write merge and adds per-digit blanking.
- Zero-wait-state slave with error response.

Parameters:
GPIO_W, 16, output and input pin count (1..32)
SEG_N, 8, number of 7-segment digits (1..8)
SYNC_STAGES, 2, input synchroniser flops (>=2)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_paddr  input  32  APB address; only [4:2] decoded
in_psel  input  1  APB select
in_penable  input  1  APB enable
in_pprot  input  3  ignored
in_pwrite  input  1  1=write
in_pwdata  input  32  write data
in_pstrb  input  4  byte-lane write strobes
in_pready  output  1  = in_psel & in_penable
in_prdata  output  32  read data, combinational from registers
in_pslverr  output  1  error response, valid when in_pready=1
gpio_out  output  GPIO_W  output pins
gpio_in  input  GPIO_W  asynchronous input pins
gpio_seg  output  8*SEG_N  digit k on [8k+7:8k]; active-low, bit7=a .. bit1=g, bit0=dp
irq  output  1  level interrupt = |IRQ_STATUS

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clock. All state updates on posedge clock.
- Transfer: access phase is in_psel & in_penable. in_pready is asserted in that same cycle, so there are no wait states.
- Register map by in_paddr[4:2]:
  - 0 OUT (RW)
  - 1 IN (RO)
  - 2 SEG (RW; nibble k = hex digit k)
  - 3 SEG_EN (RW; bit k enables digit k)
  - 4 RISE_EN (RW)
  - 5 FALL_EN (RW)
  - 6 IRQ_STATUS (R/W1C)
  - 7 unmapped
- Write rules: writes commit at the access-phase clock edge.
  - Byte lane b is updated only where in_pstrb[b]=1; unstrobed lanes keep their old value.
  - Bits at or above GPIO_W (OUT/IN/RISE/FALL/STATUS) or SEG_N (SEG_EN) or 4*SEG_N (SEG) are not stored and read as 0.
- in_pslverr=1 for any access to slot 7 and for writes to IN; such accesses have no side effects. Slot 7 reads return 0.
- Reset values:
  - OUT, SEG, RISE_EN, FALL_EN, IRQ_STATUS = 0.
  - SEG_EN = all ones.
  - gpio_out=0, irq=0.
  - Every enabled digit shows "0" (8'b00000011).
  - Synchroniser and previous-value flops = 0.
- Input path:
  - gpio_in passes through an SYNC_STAGES-deep flop chain; the final stage is s.
  - A change on gpio_in sampled at edge N reads back from IN after edge N+SYNC_STAGES-1.
  - Register p holds s delayed by one cycle.
  - rise = s & ~p & RISE_EN; fall = ~s & p & FALL_EN.
  - IRQ_STATUS bits are set on the edge after s changes and remain set until cleared.
- IRQ_STATUS W1C: a write with bit=1 in a strobed lane clears that bit; bits written 0 are unchanged.
  - If a clear and a new qualifying edge on the same bit coincide, the bit stays set (set wins).
  - Disabling RISE_EN/FALL_EN does not clear status already set.
  - irq is combinational OR of IRQ_STATUS, with no extra latency.
- Segment decode, per digit, combinational from registers:
  - Digit k enabled: hex 0-F map to 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71.
  - Digit k disabled: output FF (blank).
- Reads have no side effects; IRQ_STATUS is not clear-on-read.
- in_prdata is 0 when not in an access phase.
- Reset mid-transfer: the write is dropped, all state returns to reset values, and a pending interrupt is lost.

Test Plan:
- Reset, then read all slots -> OUT=0, SEG=0, SEG_EN=0xFF, STATUS=0; each gpio_seg byte=0x03; irq=0; slot 7 read gives pslverr=1, prdata=0.
- Write OUT=0x0000A5C3 strb=0011, then 0x0000FF00 strb=0010 -> gpio_out=0xFFC3. Write strb=0000 -> unchanged.
- Write SEG=0x89ABCDEF, SEG_EN=0x0F -> digits0..3 = 71,61,85,63; digits4..7 = FF.
- RISE_EN=0x0001, gpio_in[0] 0->1 -> IN bit0 reads 1 after 2 edges (SYNC_STAGES=2); STATUS=0x0001 and irq=1 on the next edge. Falling edge with FALL_EN=0 -> no change.
- W1C 0x0001 with a simultaneous new rise on bit0 -> STATUS stays 1. Write 0x0001 while idle -> STATUS=0, irq=0 the same cycle after the edge.
- Write IN or slot 7 -> pslverr=1 and all registers unchanged. Reset asserted during the access phase -> OUT=0, write lost.
